// File: rtl/handshake_rx.sv
// Destination side of a four-phase req/ack crossing: synchronizes src_req, captures the
// held src_data word, acks the source and queues the word in a 2-entry stream buffer.
module handshake_rx #(
    parameter int BITWIDTH    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                src_req,
    input  logic [BITWIDTH-1:0] src_data,
    output logic                dest_ack,
    output logic                rd_stream_valid,
    input  logic                rd_stream_ready,
    output logic [BITWIDTH-1:0] rd_stream_data,
    output logic                rd_stream_ok,
    output logic [15:0]         xfer_count,
    output logic                proto_err
);

    typedef enum logic [1:0] {IDLE, CAPTURE, ACK} state_t;

    state_t                   state_q, state_d;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     req_sync;
    logic                     ack_d;
    logic                     push;
    logic [1:0]               count_q;
    logic                     wr_ptr, rd_ptr;
    logic [15:0]              xfer_cnt_q;
    logic [BITWIDTH-1:0]      mem [2];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], src_req};
    end

    assign req_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            dest_ack <= 1'b0;
        end else begin
            state_q  <= state_d;
            dest_ack <= ack_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        ack_d   = dest_ack;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                ack_d = 1'b0;
                // A full buffer withholds the ack; that is the source's only backpressure.
                if (req_sync && count_q != 2'd2) state_d = CAPTURE;
            end
            CAPTURE: begin
                push    = 1'b1;
                ack_d   = 1'b1;
                state_d = ACK;
            end
            ACK: begin
                if (!req_sync) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign rd_stream_valid = (count_q != 2'd0);
    assign rd_stream_ok    = rd_stream_valid & rd_stream_ready;
    assign rd_stream_data  = rd_stream_valid ? mem[rd_ptr] : '0;
    assign xfer_count      = xfer_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            xfer_cnt_q <= 16'd0;
            proto_err  <= 1'b0;
        end else begin
            case ({push, rd_stream_ok})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
            if (push)         wr_ptr <= ~wr_ptr;
            if (rd_stream_ok) rd_ptr <= ~rd_ptr;
            if (push)         xfer_cnt_q <= xfer_cnt_q + 16'd1;
            // Request already gone while capturing: the source dropped it before seeing an ack.
            if (state_q == CAPTURE && !req_sync) proto_err <= 1'b1;
        end
    end

    // NOTE: storage is not reset; the output mux forces data to 0 while the buffer is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= src_data;
    end

endmodule

// File: tb/tb_handshake_rx.sv
// Bench for handshake_rx: directed four-phase source, scoreboard queue of expected words,
// and a negedge monitor that compares every word the stream hands out.
module tb_handshake_rx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         clk_en = 1'b0;
    logic         rst = 1'b0;
    logic         src_req = 1'b0;
    logic [W-1:0] src_data = '0;
    logic         dest_ack;
    logic         rd_stream_valid;
    logic         rd_stream_ready = 1'b0;
    logic [W-1:0] rd_stream_data;
    logic         rd_stream_ok;
    logic [15:0]  xfer_count;
    logic         proto_err;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [W-1:0] exp_q[$];
    logic [15:0]  exp_cnt = 16'd0;

    handshake_rx #(.BITWIDTH(W), .SYNC_STAGES(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .src_req         (src_req),
        .src_data        (src_data),
        .dest_ack        (dest_ack),
        .rd_stream_valid (rd_stream_valid),
        .rd_stream_ready (rd_stream_ready),
        .rd_stream_data  (rd_stream_data),
        .rd_stream_ok    (rd_stream_ok),
        .xfer_count      (xfer_count),
        .proto_err       (proto_err)
    );

    initial begin
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic level, input string name);
        for (int i = 0; i < 60; i++) begin
            if (dest_ack == level) break;
            tick(1);
        end
        check(name, 32'(dest_ack), 32'(level));
    endtask

    task automatic send(input logic [W-1:0] w);
        src_data = w;
        src_req  = 1'b1;
        exp_q.push_back(w);
        exp_cnt++;
        wait_ack(1'b1, "ack_rise");
        src_req = 1'b0;
        wait_ack(1'b0, "ack_fall");
    endtask

    task automatic drain();
        rd_stream_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0) break;
            tick(1);
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        tick(1);
        check("valid_after_drain", 32'(rd_stream_valid), 32'd0);
    endtask

    // Scoreboard monitor: a word is consumed whenever valid and ready meet.
    always @(negedge clk) begin
        if (!rst && rd_stream_valid && rd_stream_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_word: got 0x%0h expected none at %0t", rd_stream_data, $time);
            end else begin
                check("stream_data", 32'(rd_stream_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with the clock stopped: outputs must clear asynchronously.
        #2 rst = 1'b1;
        #1;
        check("rst_ack", 32'(dest_ack), 32'd0);
        check("rst_valid", 32'(rd_stream_valid), 32'd0);
        check("rst_data", 32'(rd_stream_data), 32'd0);
        check("rst_xfer", 32'(xfer_count), 32'd0);
        check("rst_perr", 32'(proto_err), 32'd0);
        clk_en = 1'b1;
        tick(2);
        rst = 1'b0;

        // Single transfer with exact latency.
        rd_stream_ready = 1'b1;
        src_data = 8'hA5;
        src_req  = 1'b1;
        exp_q.push_back(8'hA5);
        exp_cnt++;
        tick(3);
        check("e3_ack", 32'(dest_ack), 32'd0);
        check("e3_valid", 32'(rd_stream_valid), 32'd0);
        tick(1);
        check("e4_ack", 32'(dest_ack), 32'd1);
        check("e4_valid", 32'(rd_stream_valid), 32'd1);
        check("e4_ok", 32'(rd_stream_ok), 32'd1);
        tick(1);
        check("e5_valid", 32'(rd_stream_valid), 32'd0);
        src_req = 1'b0;
        tick(2);
        check("f2_ack", 32'(dest_ack), 32'd1);
        tick(1);
        check("f3_ack", 32'(dest_ack), 32'd0);
        check("single_xfer", 32'(xfer_count), 32'(exp_cnt));

        // Backpressure: two words fill the buffer, the third waits unacked.
        rd_stream_ready = 1'b0;
        send(8'h11);
        send(8'h22);
        src_data = 8'h33;
        src_req  = 1'b1;
        exp_q.push_back(8'h33);
        exp_cnt++;
        tick(20);
        check("full_no_ack", 32'(dest_ack), 32'd0);
        check("full_head", 32'(rd_stream_data), 32'h11);
        rd_stream_ready = 1'b1;
        tick(1);
        rd_stream_ready = 1'b0;
        wait_ack(1'b1, "bp_ack_rise");
        src_req = 1'b0;
        wait_ack(1'b0, "bp_ack_fall");
        check("bp_xfer", 32'(xfer_count), 32'(exp_cnt));
        drain();

        // Push and pop in the same cycle with one word already buffered.
        rd_stream_ready = 1'b0;
        send(8'h44);
        src_data = 8'h55;
        src_req  = 1'b1;
        exp_q.push_back(8'h55);
        exp_cnt++;
        tick(3);
        check("cap_valid", 32'(rd_stream_valid), 32'd1);
        rd_stream_ready = 1'b1;
        tick(1);
        rd_stream_ready = 1'b0;
        check("pp_valid", 32'(rd_stream_valid), 32'd1);
        check("pp_ack", 32'(dest_ack), 32'd1);
        tick(1);
        check("pp_hold_valid", 32'(rd_stream_valid), 32'd1);
        check("pp_hold_data", 32'(rd_stream_data), 32'h55);
        src_req = 1'b0;
        wait_ack(1'b0, "pp_ack_fall");
        drain();

        // Asynchronous reset while acking with two words buffered.
        rd_stream_ready = 1'b0;
        send(8'h66);
        src_data = 8'h77;
        src_req  = 1'b1;
        exp_q.push_back(8'h77);
        exp_cnt++;
        wait_ack(1'b1, "mid_ack_rise");
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ack", 32'(dest_ack), 32'd0);
        check("mid_rst_valid", 32'(rd_stream_valid), 32'd0);
        check("mid_rst_data", 32'(rd_stream_data), 32'd0);
        check("mid_rst_xfer", 32'(xfer_count), 32'd0);
        exp_q.delete();
        exp_cnt = 16'd0;
        src_req = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
        check("post_rst_valid", 32'(rd_stream_valid), 32'd0);

        // Counter wrap: preload near the top, then two transfers.
        force dut.xfer_cnt_q = 16'hFFFE;
        #1 release dut.xfer_cnt_q;
        exp_cnt = 16'hFFFE;
        rd_stream_ready = 1'b1;
        send(8'h88);
        check("xfer_ffff", 32'(xfer_count), 32'(exp_cnt));
        send(8'h99);
        check("xfer_wrap", 32'(xfer_count), 32'h0000);
        drain();
        check("perr_clean", 32'(proto_err), 32'd0);

        // Narrow request pulse: req_sync is already low during CAPTURE.
        src_data = 8'hAA;
        src_req  = 1'b1;
        exp_q.push_back(8'hAA);
        exp_cnt++;
        tick(1);
        src_req = 1'b0;
        tick(3);
        check("pulse_perr", 32'(proto_err), 32'd1);
        check("pulse_ack", 32'(dest_ack), 32'd1);
        tick(2);
        check("pulse_ack_fall", 32'(dest_ack), 32'd0);
        send(8'hBB);
        check("perr_sticky", 32'(proto_err), 32'd1);
        check("pulse_xfer", 32'(xfer_count), 32'(exp_cnt));
        drain();
        #2 rst = 1'b1;
        #1;
        check("perr_rst", 32'(proto_err), 32'd0);
        tick(1);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
